// File: rtl/boa_irq_ctl.sv
// boa_irq_ctl: external interrupt front-end for the Boa32 core.
// It synchronises 16 request lines and classifies each source as level or edge.
// Edge events are latched in PENDING and masked by ENABLE to drive the core irq input.
// Software access uses a word-addressed register port:
//   0 = PENDING, 1 = ENABLE, 2 = EDGE, 3 = RAW.
// Optional build macro: BOA_IRQ_SYNC_EN.
//   Defined: each source passes through sync_stages flops.
//   Undefined: a single capture register is used, and src must be synchronous to clk.
module boa_irq_ctl #(
  parameter int unsigned sync_stages = 2,
  parameter logic [15:0] edge_mask   = 16'h0000,
  parameter logic [15:0] enable_rst  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] src,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic [15:0] irq
);

  typedef enum logic [1:0] {
    A_PENDING = 2'd0,
    A_ENABLE  = 2'd1,
    A_EDGE    = 2'd2,
    A_RAW     = 2'd3
  } reg_addr_t;

  // Reject out-of-range synchroniser depths when the design is elaborated.
  if (sync_stages < 2 || sync_stages > 4) begin : g_bad_sync_stages
    $error("boa_irq_ctl: sync_stages must be in 2..4");
  end

  logic [15:0] sync;
  logic [15:0] prev;
  logic [15:0] pending;
  logic [15:0] pending_nxt;
  logic [15:0] enable_q;
  logic [15:0] edge_q;
  logic [15:0] wdata_lo;
  logic [15:0] edge_chg;
  logic [15:0] w1c;
  logic [15:0] rise;
  logic        unused_wdata_hi;

  assign wdata_lo        = reg_wdata[15:0];
  assign unused_wdata_hi = &{1'b0, reg_wdata[31:16]};

`ifdef BOA_IRQ_SYNC_EN
  logic [sync_stages-1:0][15:0] sync_chain;

  // Synchroniser shift chain: stage 0 samples src, and the last stage is sync.
  always_ff @(posedge clk) begin
    if (rst) sync_chain <= '0;
    else     sync_chain <= {sync_chain[sync_stages-2:0], src};
  end

  assign sync = sync_chain[sync_stages-1];
`else
  logic [15:0] sync_q;

  // Single capture register; the sources are already synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= src;
  end

  assign sync = sync_q;
`endif

  // Keep the previous synchronised level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= sync;
  end

  // Per-bit PENDING next state.
  // A changed EDGE bit clears PENDING on the write edge.
  // Otherwise, level sources follow sync.
  // Edge sources latch a rising edge; a new edge beats a same-cycle W1C.
  always_comb begin
    edge_chg    = '0;
    w1c         = '0;
    rise        = sync & ~prev;
    pending_nxt = '0;
    if (reg_we && reg_addr == A_EDGE)    edge_chg = wdata_lo ^ edge_q;
    if (reg_we && reg_addr == A_PENDING) w1c      = wdata_lo;
    pending_nxt = ~edge_chg & ((edge_q & (rise | (pending & ~w1c))) |
                               (~edge_q & sync));
  end

  // PENDING register.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Software-writable ENABLE and EDGE registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= enable_rst;
      edge_q   <= edge_mask;
    end else if (reg_we) begin
      if (reg_addr == A_ENABLE) enable_q <= wdata_lo;
      if (reg_addr == A_EDGE)   edge_q   <= wdata_lo;
    end
  end

  // Registered read port.
  // Sampling the current contents makes a same-cycle write return the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rdata <= '0;
    end else if (reg_re) begin
      unique case (reg_addr)
        A_PENDING: reg_rdata <= {16'h0000, pending};
        A_ENABLE:  reg_rdata <= {16'h0000, enable_q};
        A_EDGE:    reg_rdata <= {16'h0000, edge_q};
        default:   reg_rdata <= {16'h0000, sync};
      endcase
    end
  end

  assign irq = pending & enable_q;

endmodule

// File: tb/tb_boa_irq_ctl.sv
// Directed self-checking bench for boa_irq_ctl (edge_mask=00F0, enable_rst=0003).
// The expected src-to-irq latency depends on whether BOA_IRQ_SYNC_EN is defined.
module tb_boa_irq_ctl;

`ifdef BOA_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src;
  logic        reg_we;
  logic        reg_re;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic [15:0] irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rv;

  boa_irq_ctl #(
    .sync_stages(2),
    .edge_mask  (16'h00F0),
    .enable_rst (16'h0003)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_re   = 1'b1;
    reg_addr = a;
    tick();
    reg_re   = 1'b0;
    d        = reg_rdata;
  endtask

  initial begin
    rst = 1'b1; src = '0; reg_we = 1'b0; reg_re = 1'b0;
    reg_addr = '0; reg_wdata = '0;

    // Reset held for 2 cycles; strobes asserted during reset must be ignored.
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = 2'd1; reg_wdata = 32'h0000_FFFF;
    tick();
    chk("irq_in_rst", {16'h0, irq}, 32'h0);
    chk("rdata_in_rst", reg_rdata, 32'h0);
    reg_we = 1'b0; reg_re = 1'b0; reg_wdata = '0;
    tick();
    rst = 1'b0;
    chk("irq_after_rst", {16'h0, irq}, 32'h0);
    rd(2'd0, rv); chk("rst_pending", rv, 32'h0);
    rd(2'd1, rv); chk("rst_enable", rv, 32'h3);
    rd(2'd2, rv); chk("rst_edge", rv, 32'hF0);
    rd(2'd3, rv); chk("rst_raw", rv, 32'h0);

    // Level source 0: irq follows src with exactly LAT edges of latency.
    wr(2'd1, 32'h0001);
    src[0] = 1'b1;
    ticks(LAT - 1);
    chk("lvl_rise_early", {16'h0, irq}, 32'h0);
    tick();
    chk("lvl_rise", {16'h0, irq}, 32'h1);
    rd(2'd3, rv); chk("lvl_raw", rv, 32'h1);
    rd(2'd0, rv); chk("lvl_pending", rv, 32'h1);
    src[0] = 1'b0;
    ticks(LAT - 1);
    chk("lvl_fall_early", {16'h0, irq}, 32'h1);
    tick();
    chk("lvl_fall", {16'h0, irq}, 32'h0);

    // Edge source 4: a one-cycle pulse is latched and held.
    wr(2'd2, 32'h0010);
    wr(2'd1, 32'h0010);
    src[4] = 1'b1;
    tick();
    src[4] = 1'b0;
    ticks(LAT - 2);
    chk("edge_early", {16'h0, irq}, 32'h0);
    tick();
    chk("edge_set", {16'h0, irq}, 32'h10);
    ticks(3);
    chk("edge_held", {16'h0, irq}, 32'h10);
    rd(2'd0, rv); chk("edge_pending", rv, 32'h10);
    wr(2'd0, 32'h0010);
    chk("edge_w1c", {16'h0, irq}, 32'h0);
    ticks(2);
    chk("edge_w1c_stays", {16'h0, irq}, 32'h0);

    // Set beats clear: the W1C lands on the same edge as a new rising edge.
    src[4] = 1'b1;
    tick();
    src[4] = 1'b0;
    ticks(LAT + 2);
    chk("sbc_pre", {16'h0, irq}, 32'h10);
    src[4] = 1'b1;
    ticks(LAT - 1);
    wr(2'd0, 32'h0010);
    chk("sbc_set_wins", {16'h0, irq}, 32'h10);
    tick();
    chk("sbc_held", {16'h0, irq}, 32'h10);
    src[4] = 1'b0;
    ticks(LAT + 1);

    // Masking: PENDING stays visible when ENABLE is cleared.
    wr(2'd1, 32'h0000);
    chk("mask_off", {16'h0, irq}, 32'h0);
    rd(2'd0, rv); chk("mask_pending", rv, 32'h10);
    wr(2'd1, 32'h0010);
    chk("mask_on", {16'h0, irq}, 32'h10);

    // Same-cycle read and write return the pre-write value; upper data bits are ignored.
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = 2'd1; reg_wdata = 32'hFFFF_0020;
    tick();
    reg_we = 1'b0; reg_re = 1'b0; reg_wdata = '0;
    chk("rw_prewrite", reg_rdata, 32'h10);
    rd(2'd1, rv); chk("rw_postwrite", rv, 32'h20);
    chk("rw_irq", {16'h0, irq}, 32'h0);
    wr(2'd1, 32'h0010);
    chk("rw_irq_back", {16'h0, irq}, 32'h10);

    // Mid-operation reset, with a write strobe that must be ignored.
    rst = 1'b1; reg_we = 1'b1; reg_addr = 2'd1; reg_wdata = 32'h0000_FFFF;
    tick();
    rst = 1'b0; reg_we = 1'b0; reg_wdata = '0;
    chk("mrst_irq", {16'h0, irq}, 32'h0);
    rd(2'd0, rv); chk("mrst_pending", rv, 32'h0);
    rd(2'd1, rv); chk("mrst_enable", rv, 32'h3);
    rd(2'd2, rv); chk("mrst_edge", rv, 32'hF0);

    // Mode change: clearing EDGE[4] while src[4] is high.
    wr(2'd1, 32'h0010);
    src[4] = 1'b1;
    ticks(LAT + 1);
    chk("mode_latched", {16'h0, irq}, 32'h10);
    wr(2'd2, 32'h00E0);
    chk("mode_write_clr", {16'h0, irq}, 32'h0);
    tick();
    chk("mode_level", {16'h0, irq}, 32'h10);
    rd(2'd2, rv); chk("mode_edge_reg", rv, 32'hE0);
    src[4] = 1'b0;
    ticks(LAT - 1);
    chk("mode_fall_early", {16'h0, irq}, 32'h10);
    tick();
    chk("mode_fall", {16'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
